pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12: PC and offset width in bits.
REQ-002 SHALL have parameter L, default 4: LUT index width, giving 2^L offset entries.
REQ-003 SHALL have parameter S, default 4: return-address stack depth in entries.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin execution from PC 0.
REQ-007 SHALL have port stall, input, 1 bit: freeze PC, state and stack.
REQ-008 SHALL have port br_op, input, 2 bits: 00 next, 01 branch, 10 call, 11 return.
REQ-009 SHALL have port taken, input, 1 bit: branch condition, used only when br_op=01.
REQ-010 SHALL have port use_lut, input, 1 bit: 1 selects the LUT offset, 0 selects the immediate.
REQ-011 SHALL have port target_in, input, L bits: LUT index or immediate offset.
REQ-012 SHALL have port halt, input, 1 bit: stop execution.
REQ-013 SHALL have port lut_we, input, 1 bit: LUT write enable.
REQ-014 SHALL have port lut_waddr, input, L bits: LUT write index.
REQ-015 SHALL have port lut_wdata, input, D bits: LUT write data, two's complement.
REQ-016 SHALL have port pc, output, D bits: current program counter.
REQ-017 SHALL have port done, output, 1 bit: high in state DONE.
REQ-018 SHALL have ports ras_ovf and ras_unf, outputs, 1 bit each: sticky stack overflow and underflow flags.

Function
REQ-019 SHALL implement states IDLE, RUN and DONE.
REQ-020 SHALL make the following state transitions: IDLE->RUN on start (pc<=0); RUN->DONE on halt with stall low; DONE->RUN on start (pc<=0).
REQ-021 SHALL ignore halt in IDLE and DONE, and let start override halt.
REQ-022 SHALL select the offset as the sign-extended LUT[target_in] when use_lut=1, else target_in zero-extended to D bits.
REQ-023 SHALL update PC in RUN with stall low as follows: br_op 00 -> pc+1; 01 with taken -> pc+offset; 01 without taken -> pc+1.
REQ-024 SHALL update PC in RUN with stall low for br_op 10 (call) as: push pc+1, then pc<=pc+offset.
REQ-025 SHALL update PC in RUN with stall low for br_op 11 (return) as: pc<=pop.
REQ-026 SHALL compute all PC arithmetic modulo 2^D, wrapping silently.
REQ-027 SHALL give halt priority over br_op: on halt, pc holds and no push or pop occurs.
REQ-028 SHALL hold pc, state, stack and flags unchanged while stall is high, including in RUN.
REQ-029 SHALL, on call with the stack full, drop the push, still take the jump, and set ras_ovf.
REQ-030 SHALL, on return with the stack empty, set pc<=pc+1 and set ras_unf.
REQ-031 SHALL clear ras_ovf, ras_unf and the stack when start is accepted.
REQ-032 SHALL accept LUT writes in any state, including during stall, visible from the next cycle.
REQ-033 SHALL use the old LUT value when a same-cycle write and read hit the same entry.
REQ-034 SHALL hold pc in IDLE and DONE.

Reset
REQ-035 SHALL, on reset, set state to IDLE, pc=0, done=0, ras_ovf=0, ras_unf=0 and empty the stack.
REQ-036 SHALL, on reset, load LUT[0]=-5, LUT[1]=+20, LUT[2]=-1 and all other entries to 0, sign-extended to D bits.
REQ-037 SHALL give reset priority over all inputs, and reset mid-RUN SHALL abort on that edge.

Configuration
REQ-038 SHALL, with PC_RAS_EN defined, include the S-entry return stack as specified.
REQ-039 SHALL, without PC_RAS_EN, have no stack: call acts as an unconditional branch (no push), return acts as next (pc+1), and ras_ovf and ras_unf are tied to 0.

Verification
REQ-040 SHALL verify: reset, start, three br_op=00 cycles -> pc=3, done=0.
REQ-041 SHALL verify: pc=10, br_op=01, taken=1, use_lut=1, target_in=0 -> pc=5; repeat with target_in=1 -> pc=25.
REQ-042 SHALL verify (D=12): pc=0, br_op=01, taken=1, use_lut=1, target_in=2 -> pc=4095 (wrap).
REQ-043 SHALL verify (S=4, PC_RAS_EN): five calls -> ras_ovf=1; five returns -> four correct return addresses, then pc+1 with ras_unf=1.
REQ-044 SHALL verify: stall=1 with br_op=01, taken=1 and halt=1 -> pc and state unchanged; stall=0 with halt=1 -> done=1 and pc held.
REQ-045 SHALL verify: lut_we writes LUT[3]=+7 while a branch in the same cycle uses index 3 -> old value 0 (pc unchanged); the next branch -> pc+7.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between a program sequencer and its driver.
// The master drives the control inputs and the slave (the sequencer) drives pc and the status flags.
interface pc_sequencer_if #(
  parameter int D = 12,
  parameter int L = 4
);
  logic         start;
  logic         stall;
  logic [1:0]   br_op;
  logic         taken;
  logic         use_lut;
  logic [L-1:0] target_in;
  logic         halt;
  logic         lut_we;
  logic [L-1:0] lut_waddr;
  logic [D-1:0] lut_wdata;
  logic [D-1:0] pc;
  logic         done;
  logic         ras_ovf;
  logic         ras_unf;

  modport master (
    output start, stall, br_op, taken, use_lut, target_in, halt,
           lut_we, lut_waddr, lut_wdata,
    input  pc, done, ras_ovf, ras_unf
  );

  modport slave (
    input  start, stall, br_op, taken, use_lut, target_in, halt,
           lut_we, lut_waddr, lut_wdata,
    output pc, done, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, relative branches through an offset LUT.
// Define PC_RAS_EN to add the S-entry return-address stack for call/return.
module pc_sequencer #(
  parameter int D = 12,
  parameter int L = 4,
  parameter int S = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int           N   = 1 << L;
  localparam logic [D-1:0] ONE = D'(1);

  state_e              state_q, state_d;
  logic [D-1:0]        pc_q, pc_d, pc_inc, pc_br;
  logic signed [D-1:0] off_s;
  logic [D-1:0]        lut_q [N];

  // Stage 0: offset select and the two candidate next PCs (wrap mod 2^D)
  always_comb begin
    off_s  = bus.use_lut ? $signed(lut_q[bus.target_in])
                         : $signed({{(D-L){1'b0}}, bus.target_in});
    pc_inc = pc_q + ONE;
    pc_br  = pc_q + $unsigned(off_s);
  end

`ifdef PC_RAS_EN
  localparam int SPW = $clog2(S + 1);
  localparam int IW  = (S > 1) ? $clog2(S) : 1;

  logic [D-1:0]   stk_q [S];
  logic [SPW-1:0] sp_q, sp_d;
  logic [IW-1:0]  top_idx;
  logic           ovf_q, ovf_d, unf_q, unf_d, push;

  assign top_idx = IW'(sp_q - SPW'(1));
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RAS_EN
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
`endif
    if (!bus.stall) begin
      if (bus.start) begin
        state_d = RUN;
        pc_d    = '0;
`ifdef PC_RAS_EN
        sp_d    = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
`endif
      end else if (state_q == RUN) begin
        if (bus.halt) begin
          state_d = DONE;
        end else begin
          case (bus.br_op)
            2'b00: pc_d = pc_inc;
            2'b01: pc_d = bus.taken ? pc_br : pc_inc;
`ifdef PC_RAS_EN
            2'b10: begin
              pc_d = pc_br;
              if (sp_q == SPW'(S)) begin
                ovf_d = 1'b1;
              end else begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
              end
            end
            default: begin
              if (sp_q == '0) begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
              end else begin
                pc_d = stk_q[top_idx];
                sp_d = sp_q - SPW'(1);
              end
            end
`else
            2'b10:   pc_d = pc_br;
            default: pc_d = pc_inc;
`endif
          endcase
        end
      end
    end
  end

  // Stage 1: architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // LUT writes ignore stall; a same-cycle read sees the old entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) lut_q[i] <= '0;
      lut_q[0] <= D'(-5);
      lut_q[1] <= D'(20);
      lut_q[2] <= D'(-1);
    end else if (bus.lut_we) begin
      lut_q[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

`ifdef PC_RAS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk_q[IW'(sp_q)] <= pc_inc;
  end

  assign bus.ras_ovf = ovf_q;
  assign bus.ras_unf = unf_q;
`else
  // Without the stack S only gates the tie-off so both builds share a parameter list
  if (S > 0) begin : g_no_ras
    assign bus.ras_ovf = 1'b0;
    assign bus.ras_unf = 1'b0;
  end
`endif

  assign bus.pc   = pc_q;
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver pushes reference-model expectations,
// a monitor pops and compares one entry per clock; build with or without PC_RAS_EN.
module tb_pc_sequencer;
  localparam int D    = 12;
  localparam int L    = 4;
  localparam int S    = 4;
  localparam int MASK = (1 << D) - 1;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk;
  logic reset;
  pc_sequencer_if #(.D(D), .L(L)) bus ();

  pc_sequencer #(.D(D), .L(L), .S(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [D-1:0] pc;
    logic         done;
    logic         ovf;
    logic         unf;
    bit           c_en;
    int           c_id;
    logic [D-1:0] cpc;
    logic         cdone;
    logic         covf;
    logic         cunf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  // reference model: abstract machine state
  int m_st;      // 0 idle, 1 running, 2 finished
  int m_pc;
  int m_lut[1 << L];
  int m_stk[$];
  bit m_ovf, m_unf;

  bit           cx_en;
  int           cx_id;
  logic [D-1:0] cx_pc;
  logic         cx_done, cx_ovf, cx_unf;

  function automatic int sext(input int v);
    int t;
    t = v & MASK;
    if (t >= (1 << (D - 1))) t = t - (1 << D);
    return t;
  endfunction

  task automatic model(input bit rst_v, st, stl, input int o, input bit tk, ul,
                       input int tg, input bit hl, we, input int wa, input int wd);
    int off;
    if (rst_v) begin
      m_st = 0; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      m_lut[0] = -5; m_lut[1] = 20; m_lut[2] = -1;
      return;
    end
    off = ul ? m_lut[tg] : tg;
    if (!stl) begin
      if (st) begin
        m_st = 1; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (m_st == 1) begin
        if (hl) m_st = 2;
        else if (o == 0) m_pc = m_pc + 1;
        else if (o == 1) m_pc = tk ? m_pc + off : m_pc + 1;
        else if (o == 2) begin
          if (RAS) begin
            if (m_stk.size() < S) m_stk.push_back((m_pc + 1) & MASK);
            else m_ovf = 1;
          end
          m_pc = m_pc + off;
        end else begin
          if (RAS && m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc = m_pc + 1;
            if (RAS) m_unf = 1;
          end
        end
        m_pc = m_pc & MASK;
      end
    end
    if (we) m_lut[wa] = sext(wd);
  endtask

  task automatic set_const(input int id, input int pc, input bit dn, input bit ov, input bit un);
    cx_en = 1; cx_id = id; cx_pc = D'(pc); cx_done = dn; cx_ovf = ov; cx_unf = un;
  endtask

  task automatic drive(input bit rst_v, st, stl, input int o, input bit tk, ul,
                       input int tg, input bit hl, we, input int wa, input int wd);
    exp_t e;
    @(negedge clk);
    reset         = rst_v;
    bus.start     = st;
    bus.stall     = stl;
    bus.br_op     = 2'(o);
    bus.taken     = tk;
    bus.use_lut   = ul;
    bus.target_in = L'(tg);
    bus.halt      = hl;
    bus.lut_we    = we;
    bus.lut_waddr = L'(wa);
    bus.lut_wdata = D'(wd);
    model(rst_v, st, stl, o, tk, ul, tg, hl, we, wa, wd);
    cyc++;
    e.cyc = cyc; e.pc = D'(m_pc); e.done = (m_st == 2); e.ovf = m_ovf; e.unf = m_unf;
    e.c_en = cx_en; e.c_id = cx_id; e.cpc = cx_pc; e.cdone = cx_done;
    e.covf = cx_ovf; e.cunf = cx_unf;
    exp_q.push_back(e);
    cx_en = 0;
  endtask

  task automatic do_op(input int o, input bit tk, input bit ul, input int tg);
    drive(0, 0, 0, o, tk, ul, tg, 0, 0, 0, 0);
  endtask

  // monitor: one expectation per clock, sampled 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pc === e.pc && bus.done === e.done && bus.ras_ovf === e.ovf && bus.ras_unf === e.unf)
          passes++;
        else
          $display("FAIL model cyc%0d: got pc=%0d done=%b ovf=%b unf=%b, want pc=%0d done=%b ovf=%b unf=%b",
                   e.cyc, bus.pc, bus.done, bus.ras_ovf, bus.ras_unf, e.pc, e.done, e.ovf, e.unf);
        if (e.c_en) begin
          checks++;
          if (bus.pc === e.cpc && bus.done === e.cdone && bus.ras_ovf === e.covf && bus.ras_unf === e.cunf)
            passes++;
          else
            $display("FAIL const%0d: got pc=%0d done=%b ovf=%b unf=%b, want pc=%0d done=%b ovf=%b unf=%b",
                     e.c_id, bus.pc, bus.done, bus.ras_ovf, bus.ras_unf, e.cpc, e.cdone, e.covf, e.cunf);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cx_en = 0;
    reset = 1'b1;
    bus.start = 0; bus.stall = 0; bus.br_op = 0; bus.taken = 0; bus.use_lut = 0;
    bus.target_in = 0; bus.halt = 0; bus.lut_we = 0; bus.lut_waddr = 0; bus.lut_wdata = 0;

    set_const(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0);                       // IDLE holds pc
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // start
    do_op(0, 0, 0, 0);
    do_op(0, 0, 0, 0);
    set_const(2, 3, 0, 0, 0);
    do_op(0, 0, 0, 0);

    for (int i = 0; i < 6; i++) do_op(0, 0, 0, 0);
    set_const(3, 10, 0, 0, 0);
    do_op(0, 0, 0, 0);
    set_const(4, 5, 0, 0, 0);
    do_op(1, 1, 1, 0);                       // 10 + (-5)
    set_const(5, 25, 0, 0, 0);
    do_op(1, 1, 1, 1);                       // 5 + 20
    set_const(6, 26, 0, 0, 0);
    do_op(1, 0, 1, 1);                       // not taken

    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_const(7, 4095, 0, 0, 0);
    do_op(1, 1, 1, 2);                       // 0 + (-1) wraps

    // call/return: immediate offset 3 from pc 0
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      set_const(10 + i, 3 * i, 0, (RAS && i == 5), 0);
      do_op(2, 0, 0, 3);
    end
    for (int i = 1; i <= 5; i++) begin
      if (RAS) set_const(20 + i, (i < 5) ? 13 - 3 * i : 2, 0, 1, (i == 5));
      else     set_const(20 + i, 15 + i, 0, 0, 0);
      do_op(3, 0, 0, 0);
    end

    // stall freezes everything, halt then finishes
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0);
    do_op(0, 0, 0, 0);
    set_const(30, 2, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0);
    set_const(31, 2, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    set_const(32, 2, 1, 0, 0);
    do_op(0, 0, 0, 0);                       // DONE holds pc
    set_const(33, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // start beats halt

    // same-cycle LUT write and read of entry 3
    for (int i = 0; i < 4; i++) do_op(0, 0, 0, 0);
    set_const(40, 4, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 3, 0, 1, 3, 7);
    set_const(41, 11, 0, 0, 0);
    do_op(1, 1, 1, 3);

    // reset aborts a running program
    set_const(42, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 6) == 0), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, (1 << L) - 1)), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, (1 << L) - 1)),
            int'($urandom_range(0, MASK)));
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
